// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding IF/ID; owns the PC, drives a
// ready-handshaked instruction memory, holds words across stalls and drops redirected fetches.
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] pc_add4_o,
  output logic [31:0] instruction_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = redirect_pc_i & ~32'd3;
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    hold_d        = hold_q;
    imem_req_o    = 1'b0;
    imem_addr_o   = pc_q;
    valid_o       = 1'b0;
    instruction_o = 32'd0;
    pc_add4_o     = pc_inc;

    case (state_q)
      FETCH: begin
        imem_req_o    = 1'b1;
        valid_o       = imem_ready_i;
        instruction_o = imem_ready_i ? imem_rdata_i : 32'd0;
        if (redirect_i) begin
          pc_d = target;
          // An unanswered request must still complete before the new fetch starts.
          if (!imem_ready_i) begin
            addr_d  = pc_q;
            state_d = DROP;
          end
        end else if (imem_ready_i) begin
          if (stall_i) begin
            hold_d  = imem_rdata_i;
            state_d = HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HOLD: begin
        valid_o       = 1'b1;
        instruction_o = hold_q;
        if (redirect_i) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_i) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DROP: begin
        imem_req_o  = 1'b1;
        imem_addr_o = addr_q;
        if (redirect_i) begin
          pc_d = target;
        end
        if (imem_ready_i) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (rst_i) begin
      imem_req_o    = 1'b0;
      imem_addr_o   = RESET_PC;
      valid_o       = 1'b0;
      instruction_o = 32'd0;
      pc_add4_o     = RESET_PC + 32'd4;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Randomised scoreboard bench for if_fetch_unit: program-order stream model vs. accepted instructions.
`default_nettype none

module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
  localparam int          NCYC   = 4000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ready_i;
  logic [31:0] pc_add4_o;
  logic [31:0] instruction_o;
  logic        valid_o;

  int checks = 0;
  int fails  = 0;

  // Expected program-order PCs still to be delivered to IF/ID.
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .imem_ready_i  (imem_ready_i),
    .pc_add4_o     (pc_add4_o),
    .instruction_o (instruction_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  // Driver: new inputs just after each rising edge; redirects and resets rewrite the expected stream.
  initial begin
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    imem_ready_i  = 1'b1;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst_i        = ($urandom_range(0, 99) == 0);
      stall_i      = ($urandom_range(0, 9) < 3);
      imem_ready_i = ($urandom_range(0, 9) < 6);
      redirect_i   = ($urandom_range(0, 99) < 8);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      if (rst_i) begin
        exp_q.delete();
        exp_q.push_back(RST_PC);
      end else if (redirect_i) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc_i & ~32'd3);
      end
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Monitor: samples mid-cycle, compares accepted instructions against the stream model.
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [31:0] e;
    int          idle;
    prev_wait = 1'b0;
    prev_addr = 32'd0;
    idle      = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        checks++;
        if ({imem_req_o, valid_o, instruction_o, pc_add4_o} !== {1'b0, 1'b0, 32'd0, RST_PC + 32'd4}) begin
          fails++;
          $display("FAIL reset_outputs: got req=%b valid=%b instr=%h pc4=%h, want req=0 valid=0 instr=0 pc4=%h",
                   imem_req_o, valid_o, instruction_o, pc_add4_o, RST_PC + 32'd4);
        end
        prev_wait = 1'b0;
        idle      = 0;
      end else begin
        if (prev_wait && imem_req_o) begin
          checks++;
          if (imem_addr_o !== prev_addr) begin
            fails++;
            $display("FAIL addr_stable: got %h, want %h", imem_addr_o, prev_addr);
          end
        end
        if (!valid_o && instruction_o !== 32'd0) begin
          checks++;
          fails++;
          $display("FAIL bubble_nop: got instr=%h with valid=0, want 00000000", instruction_o);
        end
        if (valid_o && !stall_i && !redirect_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL accept_unexpected: got pc4=%h, want no instruction", pc_add4_o);
          end else begin
            e = exp_q.pop_front();
            if ({pc_add4_o, instruction_o} !== {e + 32'd4, mem_word(e)}) begin
              fails++;
              $display("FAIL accept: got pc4=%h instr=%h, want pc4=%h instr=%h",
                       pc_add4_o, instruction_o, e + 32'd4, mem_word(e));
            end
            exp_q.push_back(e + 32'd4);
          end
          idle = 0;
        end else if (redirect_i) begin
          idle = 0;
        end else begin
          idle++;
          if (idle > 200) begin
            checks++;
            fails++;
            $display("FAIL progress: got no accepted instruction for %0d cycles, want one within 200", idle);
            idle = 0;
          end
        end
        prev_wait = imem_req_o && !imem_ready_i;
        prev_addr = imem_addr_o;
      end
    end
  end

endmodule

`default_nettype wire
